// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, ExcCode values, Status/Cause field positions
// and the per-register MTC0 writable-bit mask.
package cp0_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_TR   = 5'd13;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int ST_IM_HI  = 15;
    localparam int CA_IP_LO  = 8;
    localparam int CA_IP_HI  = 15;
    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;
    localparam int CA_BD     = 31;

    localparam logic [31:0] STATUS_RST  = 32'h1000_0000;
    localparam logic [31:0] CONFIG_VAL  = 32'h0000_8000;
    localparam logic [31:0] CAUSE_WMASK = 32'h0000_0300;

    function automatic logic [31:0] wr_mask(input logic [4:0] addr);
        case (addr)
            REG_COUNT, REG_COMPARE, REG_STATUS, REG_EPC: wr_mask = 32'hFFFF_FFFF;
            REG_CAUSE:                                   wr_mask = CAUSE_WMASK;
            default:                                     wr_mask = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// cp0_exc_ctrl_if: MTC0/MFC0 port, committed exception/ERET inputs, interrupt
// lines and the flush/redirect outputs between the pipeline (master) and CP0 (slave).
interface cp0_exc_ctrl_if #(
    parameter int DATA_W     = 32,
    parameter int NUM_HW_INT = 6
);
    logic                  we_i;
    logic [4:0]            waddr_i;
    logic [4:0]            raddr_i;
    logic [DATA_W-1:0]     wdata_i;
    logic [DATA_W-1:0]     rdata_o;
    logic [NUM_HW_INT-1:0] int_i;
    logic                  exc_valid_i;
    logic [4:0]            exc_code_i;
    logic [DATA_W-1:0]     exc_pc_i;
    logic                  exc_bd_i;
    logic [DATA_W-1:0]     exc_badvaddr_i;
    logic                  eret_i;
    logic                  int_pending_o;
    logic                  timer_int_o;
    logic                  flush_o;
    logic [DATA_W-1:0]     new_pc_o;
    logic [DATA_W-1:0]     status_o;
    logic [DATA_W-1:0]     cause_o;
    logic [DATA_W-1:0]     epc_o;

    modport master (
        output we_i, waddr_i, raddr_i, wdata_i, int_i,
        output exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
        input  rdata_o, int_pending_o, timer_int_o, flush_o, new_pc_o,
        input  status_o, cause_o, epc_o
    );

    modport slave (
        input  we_i, waddr_i, raddr_i, wdata_i, int_i,
        input  exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
        output rdata_o, int_pending_o, timer_int_o, flush_o, new_pc_o,
        output status_o, cause_o, epc_o
    );
endinterface

// File: rtl/cp0_timer.sv
// cp0_timer: prescaled Count, Compare and sticky timer interrupt.
// Latency: writes visible next cycle; timer_int rises the cycle after Count==Compare.
// Backpressure: none, write strobes are accepted every cycle.
module cp0_timer #(
    parameter int DATA_W    = 32,
    parameter int COUNT_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              count_we,
    input  logic              compare_we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] count,
    output logic [DATA_W-1:0] compare,
    output logic              timer_int
);
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0] presc;
    logic          presc_wrap;
    logic          match;

    assign presc_wrap = (presc == PW'(COUNT_DIV - 1));
    assign match      = (count == compare) && (compare != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            count     <= '0;
            compare   <= '0;
            timer_int <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
                presc <= '0;
            end else if (presc_wrap) begin
                count <= count + DATA_W'(1);
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end

            // A Compare write acknowledges the interrupt even if the match holds this cycle.
            if (compare_we) begin
                compare   <= wdata;
                timer_int <= 1'b0;
            end else if (match) begin
                timer_int <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: MIPS32 CP0 register file and exception/ERET sequencer; CP0_BYPASS_EN adds same-cycle MTC0 read bypass.
// Latency: reads combinational; register updates next cycle; flush_o/new_pc_o one cycle after exc_valid_i/eret_i.
// Backpressure: none; every MTC0, exception and ERET is accepted in the cycle it is presented.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                NUM_HW_INT = 6,
    parameter int                COUNT_DIV  = 1,
    parameter logic [DATA_W-1:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [DATA_W-1:0] PRID_VAL   = 32'h0144_0102
) (
    input logic           clk,
    input logic           rst,
    cp0_exc_ctrl_if.slave bus
);
    logic [DATA_W-1:0] status_q;
    logic [DATA_W-1:0] epc_q;
    logic [DATA_W-1:0] badvaddr_q;
    logic              cause_bd;
    logic [4:0]        cause_exc;
    logic [1:0]        ip_sw;
    logic [5:0]        ip_hw;
    logic              flush_q;
    logic [DATA_W-1:0] new_pc_q;

    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] compare;
    logic              timer_int;
    logic [DATA_W-1:0] cause_val;
    logic [DATA_W-1:0] rd_raw;
    logic [DATA_W-1:0] rd_val;

    logic wr_status;
    logic wr_cause;
    logic wr_epc;

    assign wr_status = bus.we_i && (bus.waddr_i == REG_STATUS);
    assign wr_cause  = bus.we_i && (bus.waddr_i == REG_CAUSE);
    assign wr_epc    = bus.we_i && (bus.waddr_i == REG_EPC);

    cp0_timer #(
        .DATA_W    (DATA_W),
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (bus.we_i && (bus.waddr_i == REG_COUNT)),
        .compare_we (bus.we_i && (bus.waddr_i == REG_COMPARE)),
        .wdata      (bus.wdata_i),
        .count      (count),
        .compare    (compare),
        .timer_int  (timer_int)
    );

    always_comb begin
        cause_val                        = '0;
        cause_val[CA_BD]                 = cause_bd;
        cause_val[CA_IP_HI:CA_IP_LO]     = {ip_hw[5] | timer_int, ip_hw[4:0], ip_sw};
        cause_val[CA_EXC_HI:CA_EXC_LO]   = cause_exc;
    end

    // Exception beats ERET beats MTC0 on Status/Cause/EPC; Count/Compare writes are never blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= DATA_W'(STATUS_RST);
            epc_q      <= '0;
            badvaddr_q <= '0;
            cause_bd   <= 1'b0;
            cause_exc  <= '0;
            ip_sw      <= '0;
            ip_hw      <= '0;
            flush_q    <= 1'b0;
            new_pc_q   <= '0;
        end else begin
            ip_hw   <= 6'(bus.int_i);
            flush_q <= bus.exc_valid_i | bus.eret_i;
            if (bus.exc_valid_i) begin
                if (!status_q[ST_EXL]) begin
                    epc_q    <= bus.exc_pc_i - (bus.exc_bd_i ? DATA_W'(4) : '0);
                    cause_bd <= bus.exc_bd_i;
                end
                status_q[ST_EXL] <= 1'b1;
                cause_exc        <= bus.exc_code_i;
                if ((bus.exc_code_i == EXC_ADEL) || (bus.exc_code_i == EXC_ADES))
                    badvaddr_q <= bus.exc_badvaddr_i;
                new_pc_q <= EXC_VECTOR;
            end else if (bus.eret_i) begin
                status_q[ST_EXL] <= 1'b0;
                new_pc_q         <= epc_q;
            end else begin
                if (wr_status) status_q <= bus.wdata_i;
                if (wr_cause)  ip_sw    <= bus.wdata_i[CA_IP_LO +: 2];
                if (wr_epc)    epc_q    <= bus.wdata_i;
            end
        end
    end

    always_comb begin
        rd_raw = '0;
        case (bus.raddr_i)
            REG_BADVADDR: rd_raw = badvaddr_q;
            REG_COUNT:    rd_raw = count;
            REG_COMPARE:  rd_raw = compare;
            REG_STATUS:   rd_raw = status_q;
            REG_CAUSE:    rd_raw = cause_val;
            REG_EPC:      rd_raw = epc_q;
            REG_PRID:     rd_raw = PRID_VAL;
            REG_CONFIG:   rd_raw = DATA_W'(CONFIG_VAL);
            default:      rd_raw = '0;
        endcase
    end

`ifdef CP0_BYPASS_EN
    logic [DATA_W-1:0] byp_mask;
    assign byp_mask = DATA_W'(wr_mask(bus.waddr_i));
    assign rd_val   = (bus.we_i && (bus.raddr_i == bus.waddr_i))
                    ? ((rd_raw & ~byp_mask) | (bus.wdata_i & byp_mask))
                    : rd_raw;
`else
    assign rd_val = rd_raw;
`endif

    assign bus.rdata_o       = rst ? '0 : rd_val;
    assign bus.int_pending_o = status_q[ST_IE] & ~status_q[ST_EXL]
                             & (|(cause_val[CA_IP_HI:CA_IP_LO] & status_q[ST_IM_HI:ST_IM_LO]));
    assign bus.timer_int_o   = timer_int;
    assign bus.flush_o       = flush_q;
    assign bus.new_pc_o      = new_pc_q;
    assign bus.status_o      = status_q;
    assign bus.cause_o       = cause_val;
    assign bus.epc_o         = epc_q;
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed vectors for cp0_exc_ctrl (COUNT_DIV=4); expected values
// are queued by the stimulus and checked by a negedge monitor.
module tb_cp0_exc_ctrl;
    import cp0_pkg::*;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
`ifdef CP0_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'hCAFE_0000;
`else
    localparam logic [31:0] BYP_EXP = 32'h0000_0000;
`endif

    localparam int S_RDATA  = 0;
    localparam int S_PEND   = 1;
    localparam int S_TIMER  = 2;
    localparam int S_STATUS = 3;
    localparam int S_CAUSE  = 4;
    localparam int S_EPC    = 5;
    localparam int S_FLUSH  = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cp0_exc_ctrl_if #(.DATA_W(32), .NUM_HW_INT(6)) bus ();

    cp0_exc_ctrl #(
        .DATA_W     (32),
        .NUM_HW_INT (6),
        .COUNT_DIV  (4),
        .EXC_VECTOR (VEC),
        .PRID_VAL   (32'h0144_0102)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pc_q[$];
    logic        obs_vld = 1'b0;
    logic        end_chk = 1'b0;
    int          n_cmp   = 0;
    int          n_bad   = 0;

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            S_RDATA:  return bus.rdata_o;
            S_PEND:   return {31'b0, bus.int_pending_o};
            S_TIMER:  return {31'b0, bus.timer_int_o};
            S_STATUS: return bus.status_o;
            S_CAUSE:  return bus.cause_o;
            S_EPC:    return bus.epc_o;
            default:  return {31'b0, bus.flush_o};
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got;
        if (obs_vld) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL observe: nothing queued, got %h", bus.rdata_o);
            end else begin
                e   = exp_q.pop_front();
                got = sample(e.sel);
                if (got !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: got %h, expected %h", e.name, got, e.val);
                end
            end
        end
        if (bus.flush_o === 1'b1) begin
            n_cmp++;
            if (pc_q.size() == 0) begin
                n_bad++;
                $display("FAIL flush_pulse: got unexpected flush (new_pc %h), expected none", bus.new_pc_o);
            end else begin
                got = pc_q.pop_front();
                if (bus.new_pc_o !== got) begin
                    n_bad++;
                    $display("FAIL flush_new_pc: got %h, expected %h", bus.new_pc_o, got);
                end
            end
        end
        if (end_chk) begin
            n_cmp++;
            if (exp_q.size() != 0 || pc_q.size() != 0) begin
                n_bad++;
                $display("FAIL drain: got %0d checks and %0d flushes outstanding, expected 0 and 0",
                         exp_q.size(), pc_q.size());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
        obs_vld = 1'b1;
        tick();
        obs_vld = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input string name, input logic [31:0] val);
        bus.raddr_i = a;
        check(name, S_RDATA, val);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we_i    = 1'b1;
        bus.waddr_i = a;
        bus.wdata_i = d;
        tick();
        bus.we_i    = 1'b0;
    endtask

    task automatic raise(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                         input logic [31:0] bva);
        bus.exc_code_i     = code;
        bus.exc_pc_i       = pc;
        bus.exc_bd_i       = bd;
        bus.exc_badvaddr_i = bva;
        bus.exc_valid_i    = 1'b1;
        pc_q.push_back(VEC);
        tick();
        bus.exc_valid_i    = 1'b0;
    endtask

    task automatic do_eret(input logic [31:0] target);
        bus.eret_i = 1'b1;
        pc_q.push_back(target);
        tick();
        bus.eret_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.we_i = 1'b0;  bus.waddr_i = '0;  bus.raddr_i = '0;  bus.wdata_i = '0;
        bus.int_i = '0;   bus.exc_valid_i = 1'b0;  bus.exc_code_i = '0;
        bus.exc_pc_i = '0;  bus.exc_bd_i = 1'b0;  bus.exc_badvaddr_i = '0;  bus.eret_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // reset values
        rd(REG_STATUS, "rdata_in_reset", 32'h0);
        rst = 1'b0;
        rd(REG_COUNT,    "rst_count",    32'h0);
        rd(REG_BADVADDR, "rst_badvaddr", 32'h0);
        rd(REG_COMPARE,  "rst_compare",  32'h0);
        rd(REG_STATUS,   "rst_status",   32'h1000_0000);
        rd(REG_CAUSE,    "rst_cause",    32'h0);
        rd(REG_EPC,      "rst_epc",      32'h0);
        rd(REG_PRID,     "rst_prid",     32'h0144_0102);
        rd(REG_CONFIG,   "rst_config",   32'h0000_8000);
        rd(5'd3,         "unmapped_3",   32'h0);
        check("rst_timer_int", S_TIMER, 32'h0);

        // timer with prescaler 4: Count hits 10 forty cycles after Count=0
        mtc0(REG_COMPARE, 32'd10);
        mtc0(REG_COUNT, 32'd0);
        repeat (39) tick();
        check("timer_before_match", S_TIMER, 32'h0);
        rd(REG_COUNT, "count_at_40", 32'd10);
        check("timer_set", S_TIMER, 32'h1);
        check("cause_ip7_timer", S_CAUSE, 32'h0000_8000);
        mtc0(REG_COMPARE, 32'd20);
        check("timer_cleared", S_TIMER, 32'h0);
        mtc0(REG_COMPARE, 32'd0);

        // interrupts
        bus.int_i = 6'b000100;
        mtc0(REG_STATUS, 32'h0000_FF01);
        check("cause_ip4", S_CAUSE, 32'h0000_1000);
        check("pending_hw", S_PEND, 32'h1);
        mtc0(REG_STATUS, 32'h0000_FF03);
        check("pending_exl", S_PEND, 32'h0);
        check("status_write", S_STATUS, 32'h0000_FF03);
        bus.int_i = '0;
        mtc0(REG_CAUSE, 32'hFFFF_FFFF);
        check("cause_sw_mask", S_CAUSE, 32'h0000_0300);
        mtc0(REG_STATUS, 32'h0000_FF01);
        check("pending_sw", S_PEND, 32'h1);
        mtc0(REG_CAUSE, 32'h0);
        check("pending_cleared", S_PEND, 32'h0);

        // exception in delay slot, then nested exception with EXL set (back-to-back flushes)
        raise(EXC_OV, 32'h8000_1004, 1'b1, 32'h0000_DEAD);
        raise(EXC_ADEL, 32'h8000_2000, 1'b0, 32'h0000_0ABC);
        check("epc_bd_adjust", S_EPC, 32'h8000_1000);
        check("cause_nested", S_CAUSE, 32'h8000_0010);
        rd(REG_BADVADDR, "badvaddr_adel", 32'h0000_0ABC);
        check("status_exl", S_STATUS, 32'h0000_FF03);

        // ERET beats a same-cycle MTC0 EPC
        bus.we_i = 1'b1;  bus.waddr_i = REG_EPC;  bus.wdata_i = 32'h0000_5555;
        do_eret(32'h8000_1000);
        bus.we_i = 1'b0;
        check("status_eret", S_STATUS, 32'h0000_FF01);
        check("epc_eret_drop", S_EPC, 32'h8000_1000);

        // exception beats MTC0 EPC; MTC0 Count still lands
        bus.we_i = 1'b1;  bus.waddr_i = REG_EPC;  bus.wdata_i = 32'h0000_1234;
        raise(EXC_SYS, 32'h8000_3000, 1'b0, 32'h0);
        bus.waddr_i = REG_COUNT;  bus.wdata_i = 32'd5;
        raise(EXC_TR, 32'h8000_4000, 1'b1, 32'h0);
        bus.we_i = 1'b0;
        rd(REG_COUNT, "count_with_exc", 32'd5);
        check("epc_exc_wins", S_EPC, 32'h8000_3000);
        check("cause_tr", S_CAUSE, 32'h0000_0034);
        do_eret(32'h8000_3000);

        // reset in the same cycle as an exception: no flush follows
        rst = 1'b1;
        bus.exc_code_i = EXC_ADES;  bus.exc_badvaddr_i = 32'h0000_0777;  bus.exc_valid_i = 1'b1;
        tick();
        bus.exc_valid_i = 1'b0;
        rst = 1'b0;
        check("flush_after_reset", S_FLUSH, 32'h0);
        check("status_after_reset", S_STATUS, 32'h1000_0000);
        check("epc_after_reset", S_EPC, 32'h0);
        rd(REG_BADVADDR, "badvaddr_after_reset", 32'h0);

        // read of the register being written in the same cycle
        bus.we_i = 1'b1;  bus.waddr_i = REG_EPC;  bus.wdata_i = 32'hCAFE_0000;
        rd(REG_EPC, "epc_read_during_write", BYP_EXP);
        bus.we_i = 1'b0;
        check("epc_after_write", S_EPC, 32'hCAFE_0000);

        tick();
        tick();
        end_chk = 1'b1;
        tick();
        end_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Parametrised MIPS32-style coprocessor-0 register file with exception sequencer. It generalises the previous CP0 in four ways: configurable hardware interrupt count, a count prescaler, a BadVAddr register, and a registered flush/redirect handshake to the fetch stage. It sits beside the MEM stage: it takes committed exception/ERET information and MTC0 writes, and drives flush_o/new_pc_o to the pipeline controller.

Parameters:
DATA_W, 32, register width.
NUM_HW_INT, 6, external interrupt lines (1..6), mapped to Cause.IP[2+NUM_HW_INT-1:2].
COUNT_DIV, 1, Count increments once every COUNT_DIV cycles (1..16).
EXC_VECTOR, 32'hBFC00380, general exception entry PC.
PRID_VAL, 32'h01440102, PrId reset/constant value.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
we_i  in  1  MTC0 write enable
waddr_i  in  5  write register number
raddr_i  in  5  read register number
wdata_i  in  DATA_W  write data
rdata_o  out  DATA_W  combinational read data
int_i  in  NUM_HW_INT  level-sensitive hardware interrupts
exc_valid_i  in  1  committed exception this cycle
exc_code_i  in  5  ExcCode (0 int, 4 AdEL, 5 AdES, 8 Sys, 10 RI, 12 Ov, 13 Tr)
exc_pc_i  in  DATA_W  PC of faulting instruction
exc_bd_i  in  1  faulting instruction is in a delay slot
exc_badvaddr_i  in  DATA_W  faulting address (codes 4/5)
eret_i  in  1  committed ERET
int_pending_o  out  1  interrupt request to commit logic
timer_int_o  out  1  sticky timer interrupt
flush_o  out  1  one-cycle pipeline flush pulse
new_pc_o  out  DATA_W  redirect target, valid while flush_o=1
status_o, cause_o, epc_o  out  DATA_W  live register copies

Behaviour:
- Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14), PrId(15), Config(16).
- Reset values: Count=0, Compare=0, Status=32'h10000000, Cause=0, EPC=0, BadVAddr=0, Config=32'h00008000, prescaler=0, timer_int_o=0, flush_o=0, new_pc_o=0.
- Read: pure combinational. Unmapped addresses and rst=1 return 0. Without the optional feature, a read returns the pre-write value in the cycle a write occurs.
- Prescaler: counts 0..COUNT_DIV-1. Count increments on wrap, wrapping at 2^DATA_W.
- MTC0 Count writes Count and clears the prescaler; the write wins over the increment.
- Timer: timer_int_o sets on the cycle after Count==Compare while Compare!=0. It is sticky.
- MTC0 Compare writes Compare and clears timer_int_o; the clear wins over a same-cycle set.
- Cause.IP[7:2] is resampled every cycle from int_i, zero-extended. IP7 is ORed with timer_int_o.
- Writable fields: Cause.IP[1:0] (software interrupts) is writable. Status is fully writable. EPC is writable. BadVAddr, PrId and Config are read-only.
- int_pending_o = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- Priority in the same cycle: exc_valid_i > eret_i > MTC0 write to Status/Cause/EPC. The lower-priority update to those fields is dropped. A write to any other register still occurs.
- Exception entry (exc_valid_i=1):
  - If EXL=0: EPC = exc_pc_i - (exc_bd_i ? 4 : 0), Cause.BD = exc_bd_i. If EXL=1, EPC and BD are unchanged.
  - Always: EXL=1 and Cause.ExcCode = exc_code_i.
  - For codes 4/5, BadVAddr = exc_badvaddr_i.
  - Next cycle: flush_o=1 and new_pc_o = EXC_VECTOR.
- ERET: EXL=0. Next cycle: flush_o=1 and new_pc_o = EPC (value before any same-cycle write).
- flush_o is a single-cycle pulse. Back-to-back events produce back-to-back pulses.
- Reset asserted mid-sequence cancels a pending flush_o.

Optional Feature:
CP0_BYPASS_EN: when defined, reading raddr_i==waddr_i with we_i=1 returns wdata_i, masked to the writable bits, in the same cycle. Undefined: the pre-write value is returned.

Decomposition:
- Package cp0_pkg: register-number constants, ExcCode constants, Status/Cause bit-position constants (IE=0, EXL=1, IM=15:8, IP=15:8, ExcCode=6:2, BD=31).
- Sub-module cp0_timer: prescaler, Count, Compare, timer_int. Ports: clk, rst, write strobes, wdata; outputs count, compare, timer_int.

Test Plan:
- Reset, then read all 8 registers -> exact reset values; unmapped reg 3 reads 0.
- COUNT_DIV=4, Compare=10 -> Count reaches 10 after 40 cycles; timer_int_o=1 one cycle later; write Compare=20 -> timer_int_o=0 the next cycle.
- Status=32'h0000FF01, int_i[2]=1 -> Cause.IP4=1 and int_pending_o=1; set EXL -> int_pending_o=0.
- exc_valid_i with code 12, pc 32'h80001004, bd=1 -> EPC=32'h80001000, BD=1, EXL=1; next cycle flush_o=1, new_pc_o=32'hBFC00380.
- Second exception while EXL=1 -> EPC unchanged, ExcCode updated. Then ERET -> EXL=0, new_pc_o=EPC.
- Same-cycle exc_valid_i, MTC0 EPC=32'h1234, and MTC0 Count=5 -> EPC taken from exception, Count=5.
